stepper_sequencer: RTL and testbench
====================================

STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

Interface
REQ-001 SHALL have ports: clk input 1, sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst input 1, synchronous active-high reset.
REQ-003 SHALL have ports: start input 1, one-cycle move request, sampled only in IDLE.
REQ-004 SHALL have ports: move_dir input 1, direction for the requested move (1 = forward).
REQ-005 SHALL have ports: move_steps input 16, unsigned step count for the requested move.
REQ-006 SHALL have ports: half_period input 16, clk cycles per step half-phase; 0 treated as 1.
REQ-007 SHALL have ports: abort input 1, terminate the move in progress.
REQ-008 SHALL have ports: pos_clear input 1, zero the position counter.
REQ-009 SHALL have ports: step output 1, step pulse to the stepper driver.
REQ-010 SHALL have ports: dir output 1, direction to the stepper driver.
REQ-011 SHALL have ports: busy output 1, move in progress.
REQ-012 SHALL have ports: done output 1, one-cycle completion pulse.
REQ-013 SHALL have ports: aborted output 1, sticky flag: last move ended by abort.
REQ-014 SHALL have ports: steps_left output 16, remaining steps of the current move.
REQ-015 SHALL have ports: position output 16, signed two's-complement step position.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, STEP_HI, STEP_LO, DONE.
REQ-017 IDLE: start=1 SHALL latch move_dir, move_steps and max(half_period,1) as H, clear aborted, and go to SETUP; if move_steps=0, go to DONE instead.
REQ-018 start while not in IDLE SHALL be ignored; parameter inputs SHALL NOT affect a move after latching.
REQ-019 SETUP SHALL hold step=0 with dir valid for H cycles, giving direction setup time, then go to STEP_HI.
REQ-020 STEP_HI SHALL drive step=1 for H cycles, then go to STEP_LO.
REQ-021 On the STEP_HI entry cycle, steps_left SHALL decrement by 1 and position SHALL change by +1 if dir=1, else -1.
REQ-022 STEP_LO SHALL drive step=0 for H cycles, then go to STEP_HI if steps_left>0, else to DONE.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-024 busy SHALL be 1 exactly in SETUP, STEP_HI and STEP_LO.
REQ-025 Timing: with start sampled at edge 0, busy SHALL rise at cycle 1, first step rise SHALL occur at cycle 1+H, and done SHALL pulse at cycle 1+H+2*H*N for N steps.
REQ-026 dir SHALL change only when a move is latched and SHALL hold its value through IDLE.
REQ-027 abort in SETUP, STEP_HI or STEP_LO SHALL force step=0 on the next cycle, go to DONE, set aborted, and leave steps_left at its current value.
REQ-028 A truncated high phase SHALL still count as one step.
REQ-029 abort SHALL have priority over phase expiry in the same cycle, and SHALL be ignored in IDLE and DONE.
REQ-030 position SHALL wrap modulo 2^16 (32767+1 -> -32768).
REQ-031 pos_clear SHALL zero position; if it coincides with a STEP_HI entry, position SHALL become +1 or -1 (the step wins over the clear).
REQ-032 The phase counter SHALL be 16 bits; H=65535 SHALL be supported.

Reset
REQ-033 rst SHALL have priority over all inputs and SHALL produce: state IDLE, step=0, dir=0, busy=0, done=0, aborted=0, steps_left=0, position=0, phase counter 0.
REQ-034 rst during a move SHALL drop step to 0 on the next cycle with no done pulse.

Structure
REQ-035 The FSM state enum and the 16-bit count width constant SHALL live in a shared peripheral package.
REQ-036 The phase timer SHALL be one sub-module, step_phase_timer: load value, start, expire pulse.
REQ-037 step and dir SHALL be registered outputs suitable for driving the stepper driver's step/dir inputs directly.

Verification
REQ-038 Test: move_steps=3, H=2, dir=1 -> 3 step pulses, each 2 high / 2 low; first rise at cycle 3; done at cycle 15; position=+3; steps_left=0.
REQ-039 Test: move_steps=0 -> done at cycle 1, busy never 1, no step pulse, position unchanged.
REQ-040 Test: half_period=0, move_steps=2, dir=0 -> step toggles every cycle (H=1); done at cycle 6; position=-2.
REQ-041 Test: move_steps=10, H=4, abort during the 3rd high phase -> step=0 next cycle, done then, aborted=1, steps_left=7, position=+3.
REQ-042 Test: start asserted while busy with different parameters -> ignored, original move completes unchanged; pos_clear at a step entry -> position=+1.
REQ-043 Test: position preset to 32767 via 32767 forward steps, then 1 more -> -32768; rst mid-STEP_HI -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/stepper_sequencer_pkg.sv
// rtl/stepper_sequencer_pkg.sv - shared types and constants for the stepper sequencer
package stepper_sequencer_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP_HI,
    STEP_LO,
    DONE
  } state_t;

  // A half period of zero would stall the phase timer, so it runs as one cycle.
  function automatic logic [CNT_W-1:0] half_or_one(input logic [CNT_W-1:0] value);
    return (value == '0) ? CNT_W'(1) : value;
  endfunction

endpackage

// File: rtl/step_phase_timer.sv
// rtl/step_phase_timer.sv - phase timer: expire asserts in the last of load_value cycles after start
module step_phase_timer
  import stepper_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] load_value,
  input  logic             start,
  output logic             expire
);

  logic [CNT_W-1:0] count;
  logic             running;

  // Loading value-1 lets a phase of exactly load_value cycles end without an extra compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= load_value - CNT_W'(1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign expire = running && (count == '0);

endmodule

// File: rtl/stepper_sequencer.sv
// rtl/stepper_sequencer.sv - step/dir move sequencer with setup time, abort and signed position
module stepper_sequencer
  import stepper_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             move_dir,
  input  logic [CNT_W-1:0] move_steps,
  input  logic [CNT_W-1:0] half_period,
  input  logic             abort,
  input  logic             pos_clear,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left,
  output logic [CNT_W-1:0] position
);

  state_t           state;
  state_t           next_state;
  logic             timer_start;
  logic             expire;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] load_value;
  logic             latch_move;
  logic             step_entry;
  logic             abort_hit;
  logic             in_move;

  // The first phase starts on the latch edge, before h_q holds the new value.
  assign load_value = (state == IDLE) ? half_or_one(half_period) : h_q;

  step_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_value (load_value),
    .start      (timer_start),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    timer_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (move_steps == '0) begin
            next_state = DONE;
          end else begin
            next_state  = SETUP;
            timer_start = 1'b1;
          end
        end
      end
      SETUP: begin
        if (abort) begin
          next_state = DONE;
        end else if (expire) begin
          next_state  = STEP_HI;
          timer_start = 1'b1;
        end
      end
      STEP_HI: begin
        if (abort) begin
          next_state = DONE;
        end else if (expire) begin
          next_state  = STEP_LO;
          timer_start = 1'b1;
        end
      end
      STEP_LO: begin
        if (abort) begin
          next_state = DONE;
        end else if (expire) begin
          if (steps_left != '0) begin
            next_state  = STEP_HI;
            timer_start = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_move    = (state == SETUP) || (state == STEP_HI) || (state == STEP_LO);
  assign latch_move = (state == IDLE) && start;
  assign step_entry = (next_state == STEP_HI) && (state != STEP_HI);
  assign abort_hit  = in_move && abort;

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
      position   <= '0;
      h_q        <= '0;
    end else begin
      step <= (next_state == STEP_HI);
      busy <= (next_state == SETUP) || (next_state == STEP_HI) || (next_state == STEP_LO);
      done <= (next_state == DONE);

      if (latch_move) begin
        dir        <= move_dir;
        steps_left <= move_steps;
        h_q        <= half_or_one(half_period);
        aborted    <= 1'b0;
      end else if (abort_hit) begin
        aborted <= 1'b1;
      end

      if (step_entry) begin
        steps_left <= steps_left - CNT_W'(1);
      end

      // A clear on a step-entry edge is applied before the step, so the step survives.
      if (step_entry) begin
        position <= (pos_clear ? '0 : position) + (dir ? CNT_W'(1) : {CNT_W{1'b1}});
      end else if (pos_clear) begin
        position <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// tb/tb_stepper_sequencer.sv - scoreboard bench for stepper_sequencer
module tb_stepper_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        move_dir;
  logic [15:0] move_steps;
  logic [15:0] half_period;
  logic        abort;
  logic        pos_clear;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] steps_left;
  logic [15:0] position;

  stepper_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .move_dir    (move_dir),
    .move_steps  (move_steps),
    .half_period (half_period),
    .abort       (abort),
    .pos_clear   (pos_clear),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .steps_left  (steps_left),
    .position    (position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int d_cyc;
    bit ab;
    int sl;
    int pos;
    bit dr;
  } done_rec_t;

  done_rec_t   sb[$];
  int          m_e = 0;
  int          m_d = 0;
  int          m_n = 0;
  int          m_h = 1;
  bit          chk_en = 1'b0;
  int          first_rise = -1;
  int          last_done = -1;
  logic        prev_step = 1'b0;
  logic [15:0] pos_model = '0;

  // Edge numbering: edge e is the posedge after which cyc == e; the move is latched at m_e.
  always @(negedge clk) begin : monitor
    int        c;
    bit        eb;
    bit        es;
    done_rec_t r;
    if (chk_en) begin
      c  = cyc;
      eb = (m_n > 0) && (c >= m_e) && (c < m_d);
      es = eb && (c >= m_e + m_h) && (((c - m_e - m_h) % (2 * m_h)) < m_h);
      chk("busy", 32'(busy), 32'(eb));
      chk("step", 32'(step), 32'(es));
      if (step && !prev_step && first_rise < 0) first_rise = c;
      prev_step = step;
      if (done) begin
        last_done = c;
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          r = sb.pop_front();
          chk("done_cycle", 32'(c), 32'(r.d_cyc));
          chk("aborted", 32'(aborted), 32'(r.ab));
          chk("steps_left", 32'(steps_left), 32'(r.sl));
          chk("position", 32'(position), 32'(r.pos));
          chk("dir", 32'(dir), 32'(r.dr));
        end
      end
    end
  end

  // ab_off / clr_off are edge offsets from the latch edge, -1 for none.
  task automatic run_move(input bit d, input int n, input int hp, input int ab_off,
                          input int clr_off, input bit spam);
    int          h;
    int          e;
    int          dfull;
    int          dd;
    int          a;
    int          p;
    int          taken;
    int          cnt;
    int          ent;
    logic [15:0] base;
    logic [15:0] ep;
    done_rec_t   r;
    h     = (hp == 0) ? 1 : hp;
    e     = cyc + 1;
    dfull = (n == 0) ? e : e + h + 2 * h * n;
    a     = (n > 0 && ab_off >= 1 && ab_off <= h + 2 * h * n) ? e + ab_off : -1;
    dd    = (a >= 0) ? a : dfull;
    p     = (clr_off >= 0 && clr_off <= dd - e) ? e + clr_off : -1;
    taken = 0;
    cnt   = 0;
    for (int k = 0; k < n; k++) begin
      ent = e + h + 2 * h * k;
      if (ent < dd) begin
        taken++;
        if (p < 0 || ent >= p) cnt++;
      end
    end
    base    = (p >= 0) ? 16'd0 : pos_model;
    ep      = d ? base + 16'(cnt) : base - 16'(cnt);
    r.d_cyc = dd;
    r.ab    = (a >= 0);
    r.sl    = n - taken;
    r.pos   = int'(ep);
    r.dr    = d;
    m_e = e;
    m_d = dd;
    m_n = n;
    m_h = h;
    first_rise = -1;
    sb.push_back(r);
    for (int t = e; t <= dd + 1; t++) begin
      if (t == e) begin
        start       = 1'b1;
        move_dir    = d;
        move_steps  = 16'(n);
        half_period = 16'(hp);
      end else begin
        start       = spam && ($urandom_range(0, 1) == 1);
        move_dir    = 1'($urandom);
        move_steps  = 16'($urandom);
        half_period = 16'($urandom);
      end
      abort     = (t == a) || (t == dd + 1 && $urandom_range(0, 1) == 1);
      pos_clear = (t == p);
      @(negedge clk);
    end
    start     = 1'b0;
    abort     = 1'b0;
    pos_clear = 1'b0;
    pos_model = ep;
    chk("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_dir"}, 32'(dir), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_steps_left"}, 32'(steps_left), 32'd0);
    chk({tag, "_position"}, 32'(position), 32'd0);
  endtask

  initial begin
    int n;
    int hp;
    int h;
    int ab;
    int cl;
    int waited;
    rst = 1'b1; start = 1'b0; move_dir = 1'b0; move_steps = '0;
    half_period = '0; abort = 1'b0; pos_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    run_move(1'b1, 3, 2, -1, 0, 1'b0);
    chk("t38_first_rise", 32'(first_rise - m_e + 1), 32'd3);
    chk("t38_done", 32'(last_done - m_e + 1), 32'd15);
    chk("t38_position", 32'(position), 32'd3);
    chk("t38_steps_left", 32'(steps_left), 32'd0);

    run_move(1'b0, 0, 5, -1, -1, 1'b1);
    chk("t39_done", 32'(last_done - m_e + 1), 32'd1);
    chk("t39_no_step", 32'(first_rise), 32'hFFFF_FFFF);
    chk("t39_position", 32'(position), 32'd3);

    run_move(1'b0, 2, 0, -1, 0, 1'b0);
    chk("t40_done", 32'(last_done - m_e + 1), 32'd6);
    chk("t40_position", 32'(position), 32'h0000_FFFE);

    run_move(1'b1, 10, 4, 21, 0, 1'b0);
    chk("t41_aborted", 32'(aborted), 32'd1);
    chk("t41_steps_left", 32'(steps_left), 32'd7);
    chk("t41_position", 32'(position), 32'd3);

    run_move(1'b1, 3, 2, -1, -1, 1'b1);
    chk("t42_position", 32'(position), 32'd6);
    run_move(1'b1, 1, 3, -1, 3, 1'b0);
    chk("t42_clear_at_entry", 32'(position), 32'd1);

    for (int i = 0; i < 25; i++) begin
      n  = $urandom_range(0, 6);
      hp = $urandom_range(0, 4);
      h  = (hp == 0) ? 1 : hp;
      ab = (n > 0 && $urandom_range(0, 9) < 3) ? $urandom_range(1, h + 2 * h * n) : -1;
      cl = ($urandom_range(0, 9) < 3) ? $urandom_range(0, h + 2 * h * n) : -1;
      run_move(1'($urandom), n, hp, ab, cl, 1'($urandom));
    end

    run_move(1'b1, 32767, 0, -1, 0, 1'b0);
    chk("t43_pos_max", 32'(position), 32'd32767);
    run_move(1'b1, 1, 1, -1, -1, 1'b0);
    chk("t43_pos_wrap", 32'(position), 32'h0000_8000);

    chk_en = 1'b0;
    start = 1'b1; move_dir = 1'b1; move_steps = 16'd5; half_period = 16'd3;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!step && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("t43_reach_step_hi", 32'(step), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("t43_rst");
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
